sram_sp_be_rw_ctrl: RTL and testbench
=====================================

# sram_sp_be_rw_ctrl

Request front-end for the bit-enable single-port SRAM model (`ADR_WD`/`DAT_WD`/`COL_WD` geometry, one-cycle registered read).

- Accepts independent write requests (column-masked) and read requests from encoder pipeline stages through valid/ready handshakes.
- Arbitrates them onto the single SRAM port, at most one access per cycle.
- Captures returning read words into a 2-entry output FIFO with backpressure.
- Sits directly upstream of the SRAM instance and drives all of its inputs.

## Interface
Parameters:
- `ADR_WD`, 5: SRAM address width.
- `DAT_WD`, 32: data word width.
- `COL_WD`, 8: column (byte-enable lane) width; `DAT_WD` is a multiple of `COL_WD`; `COL_NUM = DAT_WD/COL_WD`.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wr_val`  in  1  write request valid.
- `wr_rdy`  out  1  write grant; accepted on `wr_val & wr_rdy`.
- `wr_adr`  in  `ADR_WD`  write address.
- `wr_msk`  in  `COL_NUM`  per-column write enable.
- `wr_dat`  in  `DAT_WD`  write data.
- `rd_val`  in  1  read request valid.
- `rd_rdy`  out  1  read grant; accepted on `rd_val & rd_rdy`.
- `rd_adr`  in  `ADR_WD`  read address.
- `out_val`  out  1  read data valid (FIFO head).
- `out_rdy`  in  1  consumer ready; pop on `out_val & out_rdy`.
- `out_dat`  out  `DAT_WD`  read data (FIFO head).
- `sram_adr`  out  `ADR_WD`  to SRAM `adr`.
- `sram_wr_ena`  out  `COL_NUM`  to SRAM `wr_ena`.
- `sram_wr_dat`  out  `DAT_WD`  to SRAM `wr_dat`.
- `sram_rd_ena`  out  1  to SRAM `rd_ena`.
- `sram_rd_dat`  in  `DAT_WD`  from SRAM `rd_dat`; valid the cycle after `sram_rd_ena`.
- `idle`  out  1  no read in flight, FIFO empty.

## Operation
- **Port outputs.** SRAM port outputs are combinational from the current-cycle grant:
  - Write grant: `sram_adr=wr_adr`, `sram_wr_ena=wr_msk`, `sram_wr_dat=wr_dat`, `sram_rd_ena=0`.
  - Read grant: `sram_adr=rd_adr`, `sram_wr_ena=0`, `sram_rd_ena=1`, `sram_wr_dat=0`.
  - No grant: all zero.
- **Read credit.** `rd_ok = (occ + inflight - pop) < 2`.
  - `occ` is FIFO occupancy, 0..2.
  - `inflight` is the read issued last cycle, 0/1.
  - `pop = out_val & out_rdy`.
- **Arbitration.** Register `last_rd` resets to 1.
  - Only `wr_val`: write granted.
  - Only `rd_val & rd_ok`: read granted.
  - Both eligible: grant the write if `last_rd=1`, else the read.
  - `last_rd` updates only on cycles where a grant is issued.
  - `rd_val` without `rd_ok` is not eligible; a pending write is granted instead.
- **Grant signals.**
  - `wr_rdy`/`rd_rdy` are the grants and may depend on `wr_val`/`rd_val`.
  - Requesters must hold val and payload stable until accepted and must not derive val from rdy.
- **All-zero mask.** `wr_msk=0` is accepted normally and consumes the cycle; memory is unchanged.
- **Ordering.**
  - Accesses execute in grant order.
  - A read granted in any cycle after a write to the same address returns the written columns merged with the untouched columns.
- **Read capture.**
  - `inflight` is set the cycle after a read grant.
  - While `inflight`, `sram_rd_dat` is pushed into the FIFO at the end of that cycle.
  - `sram_rd_dat` is ignored otherwise; the SRAM outputs zero when not reading.
- **FIFO.**
  - 2 entries with write/read pointers and `occ`; `out_dat` = head entry.
  - Push and pop in the same cycle are allowed at any occupancy; `occ` is unchanged.
  - Overflow is impossible by credit construction. Verification asserts `occ<=2` and never push when `occ==2 & !pop`.
- **Reset.** Reset mid-operation discards the in-flight read and FIFO contents; SRAM contents are not cleared.

## Timing
- **Reset values (rst=1, and the first cycle after):**
  - `wr_rdy=0`, `rd_rdy=0`.
  - `out_val=0`, `out_dat=0`.
  - All `sram_*` outputs 0.
  - `idle=1`, `occ=0`, `inflight=0`, `last_rd=1`.
- **Write latency.** Accepted in cycle t; memory updated at the edge ending t.
- **Read latency.** Accepted in cycle t:
  - `sram_rd_ena=1` in t.
  - `sram_rd_dat` valid in t+1 and pushed at the end of t+1.
  - `out_val=1` in t+2.
- **Throughput.**
  - One access per cycle.
  - With `out_rdy=1` held, back-to-back reads sustain 1 word/cycle.
  - With both requesters always valid, grants alternate W,R,W,R starting with W.
- **Backpressure.** With `out_rdy=0`, at most 2 reads are accepted; `rd_rdy` stays 0 until a pop frees a credit. A credit freed by a pop is usable in the same cycle.

## Test plan
- **Reset then write/read.** Write adr 3, dat 0x11223344, msk 4'hF; then read adr 3. Expect `out_val` 2 cycles after read accept, `out_dat=0x11223344`.
- **Partial write.** Write 0xAABBCCDD to adr 7 with msk 4'hF, then 0x00000055 with msk 4'b0001, then read adr 7. Expect 0xAABBCC55. A subsequent write with msk 4'h0 leaves the value unchanged.
- **Simultaneous requests.** Hold `wr_val`, `rd_val` and `out_rdy` high for 6 cycles. Expect grants W,R,W,R,W,R and never both rdy in one cycle.
- **Backpressure.** With `out_rdy=0`, issue 4 reads to adr 0..3. Expect exactly 2 accepted and `out_dat` = mem[0]. Raising `out_rdy` drains mem[0..3] in order with no loss or duplication.
- **Streaming.** `out_rdy=1`, 16 consecutive reads. Expect `rd_rdy=1` every cycle and 16 consecutive `out_val` cycles starting 2 cycles after the first accept.
- **Mid-operation reset.** Assert `rst` with `occ=2` and a read in flight. Expect the next cycle `out_val=0`, `idle=1`, and no stale word emitted afterwards.

Source files
------------

// File: rtl/sram_sp_be_rw_ctrl.sv
// Request front-end for the single-port bit-enable SRAM: arbitrates write and
// read requests onto one port and buffers returning read words in a 2-entry FIFO.
module sram_sp_be_rw_ctrl #(
  parameter  int ADR_WD  = 5,
  parameter  int DAT_WD  = 32,
  parameter  int COL_WD  = 8,
  localparam int COL_NUM = DAT_WD / COL_WD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_val,
  output logic               wr_rdy,
  input  logic [ADR_WD-1:0]  wr_adr,
  input  logic [COL_NUM-1:0] wr_msk,
  input  logic [DAT_WD-1:0]  wr_dat,
  input  logic               rd_val,
  output logic               rd_rdy,
  input  logic [ADR_WD-1:0]  rd_adr,
  output logic               out_val,
  input  logic               out_rdy,
  output logic [DAT_WD-1:0]  out_dat,
  output logic [ADR_WD-1:0]  sram_adr,
  output logic [COL_NUM-1:0] sram_wr_ena,
  output logic [DAT_WD-1:0]  sram_wr_dat,
  output logic               sram_rd_ena,
  input  logic [DAT_WD-1:0]  sram_rd_dat,
  output logic               idle
);

  logic [1:0]        occ_q, occ_d;
  logic              inflight_q, inflight_d;
  logic              last_rd_q, last_rd_d;
  logic              wp_q, wp_d;
  logic              rp_q, rp_d;
  logic [DAT_WD-1:0] fifo_q [2];
  logic [DAT_WD-1:0] fifo_d [2];

  logic              head_val;
  logic              pop;
  logic              push;
  logic [2:0]        credit_use;
  logic              rd_ok;
  logic              rd_elig;
  logic              wr_gnt;
  logic              rd_gnt;

  always_comb begin
    head_val   = (occ_q != 2'd0) && !rst;
    pop        = head_val && out_rdy;
    push       = inflight_q;
    // A pop this cycle frees a slot the new read may claim immediately.
    credit_use = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    rd_ok      = credit_use < 3'd2;
    rd_elig    = rd_val && rd_ok;
    wr_gnt     = !rst && wr_val && (!rd_elig || last_rd_q);
    rd_gnt     = !rst && rd_elig && (!wr_val || !last_rd_q);
  end

  always_comb begin
    occ_d      = occ_q + {1'b0, push} - {1'b0, pop};
    inflight_d = rd_gnt;
    last_rd_d  = last_rd_q;
    if (wr_gnt) last_rd_d = 1'b0;
    if (rd_gnt) last_rd_d = 1'b1;
    wp_d       = wp_q ^ push;
    rp_d       = rp_q ^ pop;
    fifo_d     = fifo_q;
    if (push) fifo_d[wp_q] = sram_rd_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      last_rd_q  <= 1'b1;
      wp_q       <= 1'b0;
      rp_q       <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      last_rd_q  <= last_rd_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
    end
  end

  // Storage needs no reset: the head is masked to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (occ_q <= 2'd2);
      assert (!(push && (occ_q == 2'd2) && !pop));
    end
  end

  always_comb begin
    wr_rdy      = wr_gnt;
    rd_rdy      = rd_gnt;
    out_val     = head_val;
    out_dat     = head_val ? fifo_q[rp_q] : '0;
    idle        = rst || (!inflight_q && (occ_q == 2'd0));
    sram_adr    = '0;
    sram_wr_ena = '0;
    sram_wr_dat = '0;
    sram_rd_ena = 1'b0;
    if (wr_gnt) begin
      sram_adr    = wr_adr;
      sram_wr_ena = wr_msk;
      sram_wr_dat = wr_dat;
    end else if (rd_gnt) begin
      sram_adr    = rd_adr;
      sram_rd_ena = 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_sp_be_rw_ctrl.sv
// Bench for sram_sp_be_rw_ctrl: directed table, multi-cycle corner sequences,
// then randomized traffic checked against a transaction-level model.
module tb_sram_sp_be_rw_ctrl;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int CN = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_val, wr_rdy, rd_val, rd_rdy, out_val, out_rdy, idle;
  logic [AW-1:0] wr_adr, rd_adr, sram_adr;
  logic [CN-1:0] wr_msk, sram_wr_ena;
  logic [DW-1:0] wr_dat, out_dat, sram_wr_dat, srd_q;
  logic          sram_rd_ena;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] smem    [32];
  logic [DW-1:0] ref_mem [32];

  always #5 clk = ~clk;

  sram_sp_be_rw_ctrl dut (
    .clk(clk), .rst(rst),
    .wr_val(wr_val), .wr_rdy(wr_rdy), .wr_adr(wr_adr), .wr_msk(wr_msk), .wr_dat(wr_dat),
    .rd_val(rd_val), .rd_rdy(rd_rdy), .rd_adr(rd_adr),
    .out_val(out_val), .out_rdy(out_rdy), .out_dat(out_dat),
    .sram_adr(sram_adr), .sram_wr_ena(sram_wr_ena), .sram_wr_dat(sram_wr_dat),
    .sram_rd_ena(sram_rd_ena), .sram_rd_dat(srd_q), .idle(idle)
  );

  // Bit-enable SRAM with one-cycle registered read, zero when not reading.
  always @(posedge clk) begin
    for (int c = 0; c < CN; c++)
      if (sram_wr_ena[c]) smem[sram_adr][c*8 +: 8] <= sram_wr_dat[c*8 +: 8];
    srd_q <= sram_rd_ena ? smem[sram_adr] : '0;
  end

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [CN-1:0] m);
    logic [DW-1:0] r;
    r = old;
    for (int c = 0; c < CN; c++)
      if (m[c]) r[c*8 +: 8] = d[c*8 +: 8];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_val = 1'b0; rd_val = 1'b0; out_rdy = 1'b0;
    next_cyc();
    rst = 1'b0;
    next_cyc();
  endtask

  task automatic do_wr(input logic [AW-1:0] a, input logic [CN-1:0] m, input logic [DW-1:0] d);
    bit got = 0;
    wr_val = 1'b1; wr_adr = a; wr_msk = m; wr_dat = d;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (wr_rdy) begin
        got = 1;
        chk("wr_sram_adr", sram_adr, a);
        chk("wr_sram_ena", sram_wr_ena, m);
        chk("wr_sram_dat", sram_wr_dat, d);
        chk("wr_sram_rd_ena", sram_rd_ena, 0);
      end
      next_cyc();
    end
    wr_val = 1'b0;
    if (!got) chk("wr_timeout", 0, 1);
    else ref_mem[a] = merge(ref_mem[a], d, m);
  endtask

  task automatic do_rd(input logic [AW-1:0] a, output logic [DW-1:0] d);
    bit got = 0;
    rd_val = 1'b1; rd_adr = a; out_rdy = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (rd_rdy) begin
        got = 1;
        chk("rd_sram_ena", sram_rd_ena, 1);
        chk("rd_sram_adr", sram_adr, a);
        chk("rd_sram_wr_ena", sram_wr_ena, 0);
      end
      next_cyc();
    end
    rd_val = 1'b0;
    if (!got) chk("rd_timeout", 0, 1);
    @(negedge clk);
    chk("rd_lat_t1_out_val", out_val, 0);
    next_cyc();
    @(negedge clk);
    chk("rd_lat_t2_out_val", out_val, 1);
    d = out_dat;
    next_cyc();
  endtask

  typedef struct {
    bit            is_rd;
    logic [AW-1:0] adr;
    logic [CN-1:0] msk;
    logic [DW-1:0] dat;
    logic [DW-1:0] exp;
  } vec_t;

  typedef struct {
    logic [DW-1:0] d;
    int            c;
  } rq_t;

  initial begin
    vec_t          vt [9];
    logic [DW-1:0] rdat;
    logic [DW-1:0] popped [$];
    rq_t           q [$];
    int            acc, nxt, mcyc;
    bit            m_last_rd, m_outval, pop_e, rd_e, gw, gr, accf;

    for (int i = 0; i < 32; i++) ref_mem[i] = '0;
    vt[0] = '{0, 5'd3, 4'hF, 32'h11223344, 32'h0};
    vt[1] = '{1, 5'd3, 4'h0, 32'h0,        32'h11223344};
    vt[2] = '{0, 5'd7, 4'hF, 32'hAABBCCDD, 32'h0};
    vt[3] = '{0, 5'd7, 4'h1, 32'h00000055, 32'h0};
    vt[4] = '{1, 5'd7, 4'h0, 32'h0,        32'hAABBCC55};
    vt[5] = '{0, 5'd7, 4'h0, 32'hFFFFFFFF, 32'h0};
    vt[6] = '{1, 5'd7, 4'h0, 32'h0,        32'hAABBCC55};
    vt[7] = '{0, 5'd7, 4'hA, 32'h12345678, 32'h0};
    vt[8] = '{1, 5'd7, 4'h0, 32'h0,        32'h12BB5655};

    // Reset with both requesters asserting: everything must stay quiet.
    rst = 1'b1; wr_val = 1'b1; rd_val = 1'b1; out_rdy = 1'b1;
    wr_adr = 5'd9; wr_msk = 4'hF; wr_dat = 32'hDEADBEEF; rd_adr = 5'd4;
    next_cyc(); next_cyc();
    for (int p = 0; p < 2; p++) begin
      @(negedge clk);
      chk("rst_wr_rdy", wr_rdy, 0);
      chk("rst_rd_rdy", rd_rdy, 0);
      chk("rst_out_val", out_val, 0);
      chk("rst_out_dat", out_dat, 0);
      chk("rst_sram_adr", sram_adr, 0);
      chk("rst_sram_wr_ena", sram_wr_ena, 0);
      chk("rst_sram_wr_dat", sram_wr_dat, 0);
      chk("rst_sram_rd_ena", sram_rd_ena, 0);
      chk("rst_idle", idle, 1);
      next_cyc();
      rst = 1'b0; wr_val = 1'b0; rd_val = 1'b0;
    end

    for (int i = 0; i < 32; i++) do_wr(i[AW-1:0], 4'hF, $urandom);

    for (int i = 0; i < 9; i++) begin
      if (vt[i].is_rd) begin
        do_rd(vt[i].adr, rdat);
        chk($sformatf("vec%0d_rd_dat", i), rdat, vt[i].exp);
      end else begin
        do_wr(vt[i].adr, vt[i].msk, vt[i].dat);
      end
    end

    // Both requesters held valid: W,R,W,R,W,R.
    do_reset();
    wr_val = 1'b1; wr_adr = 5'd9; wr_msk = 4'hF; wr_dat = 32'hCAFE0009;
    rd_val = 1'b1; rd_adr = 5'd9; out_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("sim_wr_rdy", wr_rdy, (i % 2) == 0);
      chk("sim_rd_rdy", rd_rdy, (i % 2) == 1);
      next_cyc();
    end
    wr_val = 1'b0; rd_val = 1'b0;
    ref_mem[9] = 32'hCAFE0009;
    for (int i = 0; i < 4; i++) next_cyc();
    @(negedge clk);
    chk("sim_drained_idle", idle, 1);
    next_cyc();

    // Backpressure: only two reads accepted, then drain in order.
    out_rdy = 1'b0; rd_val = 1'b1; rd_adr = 5'd0; acc = 0; nxt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      accf = rd_rdy;
      next_cyc();
      if (accf) begin acc++; nxt++; rd_adr = nxt[AW-1:0]; end
    end
    chk("bp_accepts", acc, 2);
    @(negedge clk);
    chk("bp_out_val", out_val, 1);
    chk("bp_out_dat", out_dat, ref_mem[0]);
    chk("bp_rd_rdy_held", rd_rdy, 0);
    next_cyc();
    out_rdy = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) chk("bp_credit_same_cycle", rd_rdy, 1);
      if (out_val) popped.push_back(out_dat);
      accf = rd_val && rd_rdy;
      next_cyc();
      if (accf) begin
        nxt++;
        if (nxt == 4) rd_val = 1'b0;
        else rd_adr = nxt[AW-1:0];
      end
    end
    chk("bp_pop_count", popped.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < popped.size()) chk($sformatf("bp_pop%0d", i), popped[i], ref_mem[i]);

    // Streaming: 16 back-to-back reads.
    out_rdy = 1'b1;
    for (int k = 0; k < 20; k++) begin
      rd_val = (k < 16);
      rd_adr = k[AW-1:0];
      @(negedge clk);
      if (k < 16) chk($sformatf("st_rd_rdy%0d", k), rd_rdy, 1);
      chk($sformatf("st_out_val%0d", k), out_val, (k >= 2 && k < 18));
      if (k >= 2 && k < 18) chk($sformatf("st_out_dat%0d", k), out_dat, ref_mem[k-2]);
      next_cyc();
    end
    rd_val = 1'b0;

    // Mid-operation reset with a buffered word and a read in flight.
    out_rdy = 1'b0; rd_val = 1'b1; rd_adr = 5'd0; nxt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      accf = rd_rdy;
      next_cyc();
      if (accf) begin nxt++; rd_adr = nxt[AW-1:0]; end
    end
    out_rdy = 1'b1;
    @(negedge clk);
    chk("mr_pop_grant", rd_rdy, 1);
    next_cyc();
    @(negedge clk);
    chk("mr_busy_before_rst", idle, 0);
    rd_val = 1'b0; out_rdy = 1'b0; rst = 1'b1;
    #1;
    chk("mr_rst_out_val", out_val, 0);
    chk("mr_rst_idle", idle, 1);
    next_cyc();
    rst = 1'b0; out_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mr_no_stale_out_val", out_val, 0);
      chk("mr_idle", idle, 1);
      next_cyc();
    end

    // Randomized traffic against a transaction-level model.
    do_reset();
    m_last_rd = 1; mcyc = 0;
    q.delete();
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      m_outval = (q.size() > 0) && (q[0].c + 2 <= mcyc);
      pop_e    = m_outval && out_rdy;
      rd_e     = rd_val && ((int'(q.size()) - int'(pop_e)) < 2);
      gw       = wr_val && (!rd_e || m_last_rd);
      gr       = rd_e && (!wr_val || !m_last_rd);
      chk("rnd_wr_rdy", wr_rdy, gw);
      chk("rnd_rd_rdy", rd_rdy, gr);
      chk("rnd_out_val", out_val, m_outval);
      if (m_outval) chk("rnd_out_dat", out_dat, q[0].d);
      chk("rnd_idle", idle, q.size() == 0);
      chk("rnd_sram_rd_ena", sram_rd_ena, gr);
      chk("rnd_sram_wr_ena", sram_wr_ena, gw ? wr_msk : 4'h0);
      chk("rnd_sram_wr_dat", sram_wr_dat, gw ? wr_dat : 32'h0);
      chk("rnd_sram_adr", sram_adr, gw ? wr_adr : (gr ? rd_adr : 5'd0));
      if (pop_e) void'(q.pop_front());
      if (gw) begin ref_mem[wr_adr] = merge(ref_mem[wr_adr], wr_dat, wr_msk); m_last_rd = 0; end
      if (gr) begin q.push_back('{ref_mem[rd_adr], mcyc}); m_last_rd = 1; end
      accf = wr_val && wr_rdy;
      gw   = accf;
      accf = rd_val && rd_rdy;
      next_cyc();
      mcyc++;
      if (!wr_val || gw) begin
        wr_val = ($urandom_range(0, 2) != 0);
        wr_adr = 5'($urandom_range(0, 7));
        wr_msk = 4'($urandom_range(0, 15));
        wr_dat = $urandom;
      end
      if (!rd_val || accf) begin
        rd_val = ($urandom_range(0, 2) != 0);
        rd_adr = 5'($urandom_range(0, 7));
      end
      out_rdy = ($urandom_range(0, 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1);
  end

endmodule
